// File: rtl/fetch_resp_checker.sv
// Multi-channel scoreboard for req/gnt/rvalid instruction-fetch ports: queues golden
// words per granted fetch and checks every response in order, with counters and a first-error record.
module fetch_resp_checker #(
    parameter int NB_CH          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NB_OUTSTANDING = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         enable_i,
    input  logic                                         clear_i,
    input  logic [NB_CH-1:0]                             fetch_req_i,
    input  logic [NB_CH*ADDR_WIDTH-1:0]                  fetch_addr_i,
    input  logic [NB_CH-1:0]                             fetch_gnt_i,
    input  logic [NB_CH-1:0]                             fetch_rvalid_i,
    input  logic [NB_CH*DATA_WIDTH-1:0]                  fetch_rdata_i,
    output logic [NB_CH-1:0]                             golden_req_o,
    output logic [NB_CH*ADDR_WIDTH-1:0]                  golden_addr_o,
    input  logic [NB_CH*DATA_WIDTH-1:0]                  golden_rdata_i,
    output logic [CNT_WIDTH-1:0]                         txn_count_o,
    output logic [CNT_WIDTH-1:0]                         err_count_o,
    output logic [NB_CH-1:0]                             err_sticky_o,
    output logic                                         err_valid_o,
    output logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0] err_ch_o,
    output logic [1:0]                                   err_type_o,
    output logic [ADDR_WIDTH-1:0]                        err_addr_o,
    output logic [DATA_WIDTH-1:0]                        err_exp_o,
    output logic [DATA_WIDTH-1:0]                        err_got_o
);

    localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int PTR_W = $clog2(NB_OUTSTANDING);
    localparam int OCC_W = PTR_W + 1;
    localparam int INC_W = $clog2(2 * NB_CH + 1);

    logic [NB_CH-1:0]                 rsp_chk;
    logic [NB_CH-1:0]                 rsp_err;
    logic [NB_CH-1:0]                 ovf_err;
    logic [NB_CH-1:0][1:0]            ch_type;
    logic [NB_CH-1:0][ADDR_WIDTH-1:0] ch_addr;
    logic [NB_CH-1:0][DATA_WIDTH-1:0] ch_exp;
    logic [NB_CH-1:0][DATA_WIDTH-1:0] ch_got;

    assign golden_req_o  = fetch_req_i & fetch_gnt_i & {NB_CH{enable_i}};
    assign golden_addr_o = fetch_addr_i;

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic                  pend_q;
        logic [ADDR_WIDTH-1:0] pend_addr_q;
        logic [ADDR_WIDTH-1:0] mem_addr [NB_OUTSTANDING];
        logic [DATA_WIDTH-1:0] mem_data [NB_OUTSTANDING];
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [OCC_W-1:0]      occ_q;
        logic [ADDR_WIDTH-1:0] gnt_addr;
        logic [ADDR_WIDTH-1:0] exp_addr;
        logic [DATA_WIDTH-1:0] gold;
        logic [DATA_WIDTH-1:0] got;
        logic [DATA_WIDTH-1:0] exp_data;
        logic                  rsp, empty, pop, bypass, push, ovf, mism, unexp;

        assign gnt_addr = fetch_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign gold     = golden_rdata_i[c*DATA_WIDTH +: DATA_WIDTH];
        assign got      = fetch_rdata_i[c*DATA_WIDTH +: DATA_WIDTH];

        assign rsp    = enable_i & fetch_rvalid_i[c];
        assign empty  = (occ_q == '0);
        assign pop    = rsp & ~empty;
        assign bypass = rsp & empty & pend_q;
        assign push   = pend_q & ~bypass;
        assign unexp  = rsp & empty & ~pend_q;
        // The in-flight pending entry already holds a slot, so it counts towards the depth.
        assign ovf    = golden_req_o[c] &&
                        ((OCC_W+1)'(occ_q) + (OCC_W+1)'(pend_q) >= (OCC_W+1)'(NB_OUTSTANDING));

        assign exp_data = empty ? gold : mem_data[rd_ptr_q];
        assign exp_addr = empty ? pend_addr_q : mem_addr[rd_ptr_q];
        assign mism     = (pop | bypass) && (got !== exp_data);

        assign rsp_chk[c] = pop | bypass;
        assign rsp_err[c] = mism | unexp;
        assign ovf_err[c] = ovf;
        assign ch_type[c] = mism ? 2'b01 : (unexp ? 2'b10 : 2'b11);
        assign ch_addr[c] = mism ? exp_addr : (unexp ? '0 : gnt_addr);
        assign ch_exp[c]  = mism ? exp_data : '0;
        assign ch_got[c]  = (mism | unexp) ? got : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q   <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                pend_q <= golden_req_o[c] & ~ovf;
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      occ_q <= occ_q + 1'b1;
                else if (pop && !push) occ_q <= occ_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (golden_req_o[c]) pend_addr_q <= gnt_addr;
            if (push) begin
                mem_addr[wr_ptr_q] <= pend_addr_q;
                mem_data[wr_ptr_q] <= gold;
            end
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [INC_W-1:0]     b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    logic [INC_W-1:0]      txn_inc;
    logic [INC_W-1:0]      err_inc;
    logic                  any_err;
    logic [CH_W-1:0]       sel_ch;
    logic [1:0]            sel_type;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_exp;
    logic [DATA_WIDTH-1:0] sel_got;

    // Walk downwards so the lowest erring channel is the last (winning) assignment.
    always_comb begin
        txn_inc  = '0;
        err_inc  = '0;
        any_err  = 1'b0;
        sel_ch   = '0;
        sel_type = '0;
        sel_addr = '0;
        sel_exp  = '0;
        sel_got  = '0;
        for (int c = NB_CH - 1; c >= 0; c--) begin
            txn_inc = txn_inc + INC_W'(rsp_chk[c]);
            err_inc = err_inc + INC_W'(rsp_err[c]) + INC_W'(ovf_err[c]);
            if (rsp_err[c] || ovf_err[c]) begin
                any_err  = 1'b1;
                sel_ch   = CH_W'(c);
                sel_type = ch_type[c];
                sel_addr = ch_addr[c];
                sel_exp  = ch_exp[c];
                sel_got  = ch_got[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_o  <= '0;
            err_count_o  <= '0;
            err_sticky_o <= '0;
            err_valid_o  <= 1'b0;
            err_ch_o     <= '0;
            err_type_o   <= '0;
            err_addr_o   <= '0;
            err_exp_o    <= '0;
            err_got_o    <= '0;
        end else if (clear_i) begin
            txn_count_o  <= '0;
            err_count_o  <= '0;
            err_sticky_o <= '0;
            err_valid_o  <= 1'b0;
            err_ch_o     <= '0;
            err_type_o   <= '0;
            err_addr_o   <= '0;
            err_exp_o    <= '0;
            err_got_o    <= '0;
        end else begin
            txn_count_o  <= sat_add(txn_count_o, txn_inc);
            err_count_o  <= sat_add(err_count_o, err_inc);
            err_sticky_o <= err_sticky_o | rsp_err | ovf_err;
            if (!err_valid_o && any_err) begin
                err_valid_o <= 1'b1;
                err_ch_o    <= sel_ch;
                err_type_o  <= sel_type;
                err_addr_o  <= sel_addr;
                err_exp_o   <= sel_exp;
                err_got_o   <= sel_got;
            end
        end
    end

endmodule

// File: tb/tb_fetch_resp_checker.sv
// Bench for fetch_resp_checker: vector table, directed multi-cycle sequences and
// random traffic compared each cycle against a queue-based reference model.
module tb_fetch_resp_checker;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NO  = 4;
    localparam int CW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable, clear;
    logic [NCH-1:0]    fetch_req, fetch_gnt, fetch_rvalid;
    logic [NCH*AW-1:0] fetch_addr;
    logic [NCH*DW-1:0] fetch_rdata;
    logic [NCH-1:0]    golden_req;
    logic [NCH*AW-1:0] golden_addr;
    logic [NCH*DW-1:0] golden_rdata;
    logic [CW-1:0]     txn_count, err_count;
    logic [NCH-1:0]    err_sticky;
    logic              err_valid;
    logic              err_ch;
    logic [1:0]        err_type;
    logic [AW-1:0]     err_addr;
    logic [DW-1:0]     err_exp, err_got;

    always #5 clk = ~clk;

    fetch_resp_checker #(
        .NB_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_OUTSTANDING(NO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_i(clear),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_i(fetch_gnt),
        .fetch_rvalid_i(fetch_rvalid), .fetch_rdata_i(fetch_rdata),
        .golden_req_o(golden_req), .golden_addr_o(golden_addr), .golden_rdata_i(golden_rdata),
        .txn_count_o(txn_count), .err_count_o(err_count), .err_sticky_o(err_sticky),
        .err_valid_o(err_valid), .err_ch_o(err_ch), .err_type_o(err_type),
        .err_addr_o(err_addr), .err_exp_o(err_exp), .err_got_o(err_got)
    );

    function automatic logic [31:0] gfun(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h208) return 32'hCAFEF00D;
        return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
    endfunction

    // Golden memory: one-cycle lookup of whatever address is presented.
    always @(posedge clk)
        for (int c = 0; c < NCH; c++) golden_rdata[c*DW +: DW] <= gfun(fetch_addr[c*AW +: AW]);

    // Reference model state
    logic [31:0] mq [NCH][$];
    bit          m_pend [NCH];
    logic [31:0] m_paddr [NCH];
    longint      m_txn, m_err;
    logic [1:0]  m_sticky;
    bit          m_ev;
    logic        m_ch;
    logic [1:0]  m_type;
    logic [31:0] m_addr, m_exp, m_got;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_pend[c]  = 0;
            m_paddr[c] = '0;
        end
        m_txn = 0; m_err = 0; m_sticky = '0; m_ev = 0;
        m_ch = 0; m_type = '0; m_addr = '0; m_exp = '0; m_got = '0;
    endtask

    task automatic model_step();
        int          ntx, ner;
        bit          found;
        logic        rc;
        logic [1:0]  rt, ns;
        logic [31:0] ra, re, rg;
        ntx = 0; ner = 0; found = 0; rc = 0; rt = '0; ra = '0; re = '0; rg = '0; ns = '0;
        for (int c = 0; c < NCH; c++) begin
            int          occ0;
            bit          pend0, rsp, byp, rerr, g, ovf;
            logic [31:0] got, ea, ed;
            logic [1:0]  ty;
            occ0 = mq[c].size();
            pend0 = m_pend[c];
            rsp = enable && fetch_rvalid[c];
            got = fetch_rdata[c*DW +: DW];
            byp = 0; rerr = 0; ea = '0; ed = '0; ty = '0;
            if (rsp) begin
                if (occ0 > 0) begin
                    ea = mq[c].pop_front();
                    ed = gfun(ea);
                    ntx++;
                    if (got !== ed) begin rerr = 1; ty = 2'b01; end
                end else if (pend0) begin
                    ea = m_paddr[c];
                    ed = gfun(ea);
                    byp = 1;
                    ntx++;
                    if (got !== ed) begin rerr = 1; ty = 2'b01; end
                end else begin
                    rerr = 1; ty = 2'b10;
                end
            end
            if (pend0 && !byp) mq[c].push_back(m_paddr[c]);
            g   = enable && fetch_req[c] && fetch_gnt[c];
            ovf = g && (occ0 + int'(pend0) >= NO);
            if (rerr) begin
                ner++; ns[c] = 1'b1;
                if (!found) begin found = 1; rc = c[0]; rt = ty; ra = ea; re = ed; rg = got; end
            end
            if (ovf) begin
                ner++; ns[c] = 1'b1;
                if (!found) begin
                    found = 1; rc = c[0]; rt = 2'b11; ra = fetch_addr[c*AW +: AW]; re = '0; rg = '0;
                end
            end
            m_pend[c] = g && !ovf;
            if (g) m_paddr[c] = fetch_addr[c*AW +: AW];
        end
        if (clear) begin
            m_txn = 0; m_err = 0; m_sticky = '0; m_ev = 0;
            m_ch = 0; m_type = '0; m_addr = '0; m_exp = '0; m_got = '0;
        end else begin
            m_txn = (m_txn + ntx > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_txn + ntx;
            m_err = (m_err + ner > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_err + ner;
            m_sticky = m_sticky | ns;
            if (!m_ev && found) begin
                m_ev = 1; m_ch = rc; m_type = rt; m_addr = ra; m_exp = re; m_got = rg;
            end
        end
    endtask

    task automatic compare_all();
        chk("txn_count", 64'(txn_count), 64'(m_txn));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("err_valid", 64'(err_valid), 64'(m_ev));
        chk("err_ch", 64'(err_ch), 64'(m_ch));
        chk("err_type", 64'(err_type), 64'(m_type));
        chk("err_addr", 64'(err_addr), 64'(m_addr));
        chk("err_exp", 64'(err_exp), 64'(m_exp));
        chk("err_got", 64'(err_got), 64'(m_got));
    endtask

    task automatic step(input logic en, input logic clr, input logic [1:0] rq, input logic [1:0] gt,
                        input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        enable = en; clear = clr; fetch_req = rq; fetch_gnt = gt; fetch_rvalid = rv;
        fetch_addr = {a1, a0}; fetch_rdata = {d1, d0};
        #1;
        chk("golden_req", 64'(golden_req), 64'(rq & gt & {2{en}}));
        chk("golden_addr", 64'(golden_addr), {a1, a0});
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] next_exp(input int c);
        if (mq[c].size() > 0) return gfun(mq[c][0]);
        if (m_pend[c]) return gfun(m_paddr[c]);
        return $urandom;
    endfunction

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0]  rq, gt, rv;
            logic [31:0] a [2];
            logic [31:0] d [2];
            logic        en, clr;
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) begin
                rq[c] = $urandom_range(0, 1);
                gt[c] = rq[c] & ($urandom_range(0, 2) != 0);
                rv[c] = ($urandom_range(0, 4) < 2);
                a[c]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                d[c]  = next_exp(c);
                if ($urandom_range(0, 9) == 0) d[c] = d[c] ^ 32'h1;
            end
            step(en, clr, rq, gt, rv, a[0], a[1], d[0], d[1]);
        end
    endtask

    typedef struct {
        logic [1:0]  req, gnt, rv;
        logic        clr;
        logic [31:0] a0, d0, d1;
        logic [31:0] e_txn, e_err;
        logic [1:0]  e_sticky;
        logic        e_ev, e_ch;
        logic [1:0]  e_type;
        logic [31:0] e_got;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0,
                   32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[1] = '{2'b00, 2'b00, 2'b01, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0,
                   32'd1, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[2] = '{2'b00, 2'b00, 2'b10, 1'b0, 32'h0, 32'h0, 32'h55,
                   32'd1, 32'd1, 2'b10, 1'b1, 1'b1, 2'b10, 32'h55};
        tbl[3] = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0,
                   32'd1, 32'd1, 2'b10, 1'b1, 1'b1, 2'b10, 32'h55};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0,
                   32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};

        rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
        fetch_req = '0; fetch_gnt = '0; fetch_rvalid = '0; fetch_addr = '0; fetch_rdata = '0;
        #12;
        model_reset();
        compare_all();
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        compare_all();

        // Single fetch through the bypass path, unexpected rvalid, hold, then clear
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tbl[i].clr, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].a0, 32'h0,
                 tbl[i].d0, tbl[i].d1);
            chk($sformatf("vec%0d_txn", i), 64'(txn_count), 64'(tbl[i].e_txn));
            chk($sformatf("vec%0d_err", i), 64'(err_count), 64'(tbl[i].e_err));
            chk($sformatf("vec%0d_sticky", i), 64'(err_sticky), 64'(tbl[i].e_sticky));
            chk($sformatf("vec%0d_valid", i), 64'(err_valid), 64'(tbl[i].e_ev));
            chk($sformatf("vec%0d_ch", i), 64'(err_ch), 64'(tbl[i].e_ch));
            chk($sformatf("vec%0d_type", i), 64'(err_type), 64'(tbl[i].e_type));
            chk($sformatf("vec%0d_got", i), 64'(err_got), 64'(tbl[i].e_got));
        end

        // Channel 1: four back-to-back grants, responses five cycles after the first
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 32'h0, 32'(4 * i), 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 32'h0, 32'h0, 32'h0, gfun(32'(4 * i)));
        chk("t2_txn", 64'(txn_count), 64'd4);
        chk("t2_err", 64'(err_count), 64'd0);

        // Channel 0: third response corrupted
        step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 32'h200, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 32'h204, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 32'h208, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, gfun(32'h200), 32'h0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, gfun(32'h204), 32'h0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'h12345678, 32'h0);
        chk("t3_valid", 64'(err_valid), 64'd1);
        chk("t3_type", 64'(err_type), 64'd1);
        chk("t3_ch", 64'(err_ch), 64'd0);
        chk("t3_addr", 64'(err_addr), 64'h208);
        chk("t3_exp", 64'(err_exp), 64'hCAFEF00D);
        chk("t3_got", 64'(err_got), 64'h12345678);
        chk("t3_sticky", 64'(err_sticky), 64'd1);
        chk("t3_txn", 64'(txn_count), 64'd7);

        // Channel 0: fifth grant overflows, the four queued entries still check clean
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 32'h300 + 32'(4 * i), 32'h0, 32'h0, 32'h0);
        chk("t5_type", 64'(err_type), 64'd3);
        chk("t5_addr", 64'(err_addr), 64'h310);
        chk("t5_err", 64'(err_count), 64'd1);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, gfun(32'h300 + 32'(4 * i)), 32'h0);
        chk("t5_err_after", 64'(err_count), 64'd1);
        chk("t5_txn_after", 64'(txn_count), 64'd4);

        // Both channels mismatch together, then clear with entries still queued
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 32'h400, 32'h500, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 32'h404, 32'h504, 32'h0, 32'h0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, ~gfun(32'h400), ~gfun(32'h500));
        chk("t6_err", 64'(err_count), 64'd2);
        chk("t6_ch", 64'(err_ch), 64'd0);
        chk("t6_sticky", 64'(err_sticky), 64'd3);
        chk("t6_addr", 64'(err_addr), 64'h400);
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t6_clr_valid", 64'(err_valid), 64'd0);
        chk("t6_clr_err", 64'(err_count), 64'd0);
        chk("t6_clr_sticky", 64'(err_sticky), 64'd0);
        step(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, gfun(32'h404), gfun(32'h504));
        chk("t6_txn", 64'(txn_count), 64'd2);
        chk("t6_err_after", 64'(err_count), 64'd0);

        rand_steps(2500);

        // Asynchronous reset in the middle of traffic
        enable = 1'b1; clear = 1'b0; fetch_req = '0; fetch_gnt = '0; fetch_rvalid = '0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        rand_steps(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_resp_checker.md
Name: fetch_resp_checker

Overview:
- Multi-channel self-checking scoreboard for instruction-fetch interfaces (req/gnt/rvalid protocol) in cache benches.
- Generalises the single-outstanding, single-core rdata compare to NB_CH cores, each with up to NB_OUTSTANDING in-flight fetches.
- Each granted fetch is looked up in a golden memory and the expected word is queued per channel. Every rvalid is checked in order against its queued word.
- Reports sticky errors, saturating counters and a first-error record. Synthesisable, so it can also run on FPGA/emulation benches.

Parameters:
- NB_CH, 2, number of fetch channels checked.
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, fetch data width.
- NB_OUTSTANDING, 4, per-channel queue depth; power of two, at least 2.
- CNT_WIDTH, 32, width of the transaction and error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  checking enabled. When low: no pushes, no compares, no counting; queues keep their contents.
- clear_i  in  1  synchronous clear of counters, sticky flags and the error record. Queues are not affected.
- fetch_req_i  in  NB_CH  per-channel fetch request.
- fetch_addr_i  in  NB_CH*ADDR_WIDTH  per-channel fetch address; channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- fetch_gnt_i  in  NB_CH  per-channel grant.
- fetch_rvalid_i  in  NB_CH  per-channel response valid.
- fetch_rdata_i  in  NB_CH*DATA_WIDTH  per-channel response data.
- golden_req_o  out  NB_CH  golden lookup strobe, equal to fetch_req_i & fetch_gnt_i & enable_i (combinational).
- golden_addr_o  out  NB_CH*ADDR_WIDTH  golden lookup address, equal to fetch_addr_i.
- golden_rdata_i  in  NB_CH*DATA_WIDTH  golden data, valid exactly 1 cycle after golden_req_o.
- txn_count_o  out  CNT_WIDTH  total checked responses, all channels.
- err_count_o  out  CNT_WIDTH  total errors of all kinds.
- err_sticky_o  out  NB_CH  per-channel sticky error flag.
- err_valid_o  out  1  first-error record is valid.
- err_ch_o  out  $clog2(NB_CH) (min 1)  channel of the first error.
- err_type_o  out  2  type of the first error: 01 mismatch, 10 unexpected rvalid, 11 overflow.
- err_addr_o  out  ADDR_WIDTH  address of the first error.
- err_exp_o  out  DATA_WIDTH  expected data of the first error.
- err_got_o  out  DATA_WIDTH  received data of the first error.

Behaviour:
- Reset: all queues empty, pending flags 0, all outputs 0 except golden_* (combinational).
- Per channel: pending register set in the cycle after golden_req_o, holding the captured address. In that next cycle, {addr, golden_rdata_i} is pushed into the channel FIFO (depth NB_OUTSTANDING).
- Response, queue non-empty: pop the head and compare against fetch_rdata_i with the !== rule, so X/Z counts as a mismatch.
- Response, queue empty but push this cycle: bypass; compare directly against golden_rdata_i and push nothing.
- Response, queue empty and no push: unexpected-rvalid error; addr and exp recorded as 0.
- Simultaneous push and pop on a non-empty queue: occupancy unchanged, order preserved.
- Overflow: grant while occupancy + pending == NB_OUTSTANDING. Raise an overflow error, clear pending, drop the entry, and record the grant address.
- Counters: txn_count increments by the number of checked responses per cycle, summed across channels. err_count increments by the number of errors per cycle. Both saturate at all-ones.
- Sticky flags: err_sticky_o[c] is set by any error on channel c.
- Error record: captured once, when err_valid_o is 0; if several channels err in the same cycle, the lowest channel index wins. Once valid, it is held until clear_i.
- Update timing: all status outputs update the cycle after the event (registered).
- Clear priority: clear_i has priority over same-cycle increments and the record capture. Events in the clear cycle are lost.
- enable_i deasserted mid-flight: pending entries still push, but responses are ignored. The bench flushes or resets before re-enabling.
- Reset mid-operation: queues are discarded immediately (asynchronous).

Test Plan:
1. Channel 0: single fetch, addr 0x100, golden 0xDEADBEEF, rvalid 1 cycle after grant with 0xDEADBEEF → bypass path used; txn_count=1, err_count=0.
2. Channel 1: 4 back-to-back grants 0x0,0x4,0x8,0xC, responses start 5 cycles later with the golden values in order → txn_count=4, no error; simultaneous push/pop keeps occupancy ≤4.
3. Channel 0: 3rd response has rdata 0x12345678 vs expected 0xCAFEF00D at addr 0x208 → err_valid=1, err_type=01, err_addr=0x208, err_exp=0xCAFEF00D, err_got=0x12345678, err_sticky=01.
4. Channel 1: rvalid with no grant outstanding → err_type=10, err_ch=1, err_count increments by 1.
5. NB_OUTSTANDING=4: 5th grant on channel 0 with no responses → err_type=11, addr of the 5th grant recorded; subsequent 4 responses check clean.
6. Channel 0 and channel 1 mismatch in the same cycle → err_count += 2, err_ch=0, both sticky bits set. Then clear_i → all status outputs 0, queues intact; an in-order response afterwards checks clean.
